// File: rtl/flip_flop_fifo_with_counter.sv
// Flop-array FIFO with show-ahead read data; an occupancy counter drives empty/full.
// Write visible 1 cycle after the push edge; push on full is dropped unless a pop is accepted the same cycle.
module flip_flop_fifo_with_counter #(
    parameter int width = 8,
    parameter int depth = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] write_data,
    output logic [width-1:0] read_data,
    output logic             empty,
    output logic             full
);
    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth + 1);

    logic [width-1:0] r_mem [depth];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;

    logic             w_push_acc;
    logic             w_pop_acc;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;

    assign empty = (r_cnt == '0);
    assign full  = (r_cnt == CW'(depth));

    // A pop on full frees the slot being written, so the push may proceed.
    assign w_push_acc = push & (~full | pop);
    assign w_pop_acc  = pop & ~empty;

    // Explicit wrap keeps non-power-of-two depths correct.
    assign w_wr_ptr_nxt = (r_wr_ptr == PW'(depth - 1)) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == PW'(depth - 1)) ? '0 : r_rd_ptr + PW'(1);

    assign read_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_flip_flop_fifo_with_counter.sv
// Scoreboard bench: stimulus updates a queue model and queues expected data/flags; a monitor checks them.
module tb_flip_flop_fifo_with_counter;
    localparam int W = 8;
    localparam int D = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         push = 1'b0;
    logic         pop = 1'b0;
    logic [W-1:0] write_data = '0;
    logic [W-1:0] read_data;
    logic         empty;
    logic         full;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] model[$];   // contents the FIFO should hold
    logic [W-1:0] exp_q[$];   // words the monitor should see on accepted pops
    logic [1:0]   flag_q[$];  // {empty, full} expected during each driven cycle

    flip_flop_fifo_with_counter #(.width(W), .depth(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .write_data (write_data),
        .read_data  (read_data),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of requests and advance the reference queue.
    task automatic step(input logic p, input logic q, input logic [W-1:0] d);
        bit push_ok;
        bit pop_ok;
        @(negedge clk);
        flag_q.push_back({model.size() == 0, model.size() == D});
        push       = p;
        pop        = q;
        write_data = d;
        pop_ok  = q && (model.size() > 0);
        push_ok = p && ((model.size() < D) || q);
        if (pop_ok) exp_q.push_back(model.pop_front());
        if (push_ok) model.push_back(d);
    endtask

    // Monitor: samples mid-cycle while requests are stable.
    initial begin
        logic [1:0] f;
        forever begin
            @(negedge clk);
            #1;
            if (flag_q.size() > 0) begin
                f = flag_q.pop_front();
                check("empty_flag", {31'd0, empty}, {31'd0, f[1]});
                check("full_flag", {31'd0, full}, {31'd0, f[0]});
                if (pop && !empty) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pop_data", 32'd1, 32'd0);
                    end else begin
                        check("read_data", {24'd0, read_data}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] pat [5];
        int r;
        bit p, q;
        pat = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};

        #12 rst = 1'b1;
        #1;
        check("reset_empty", {31'd0, empty}, 32'd1);
        check("reset_full", {31'd0, full}, 32'd0);

        // Fill and drain
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, pat[i]);
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Back-to-back streaming
        step(1'b1, 1'b0, pat[0]);
        step(1'b1, 1'b0, pat[1]);
        for (int i = 0; i < 25; i++) step(1'b1, 1'b1, pat[(i + 2) % 5]);
        while (model.size() > 0) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Push+pop while full, then illegal push on full
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, 8'h10 + W'(i));
        step(1'b1, 1'b1, 8'hAA);
        step(1'b1, 1'b0, 8'h55);
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, '0);

        // Pop while empty, push+pop while empty, then first pushed word is read
        step(1'b0, 1'b1, '0);
        step(1'b1, 1'b1, 8'h66);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h30 + W'(i));
        step(1'b0, 1'b0, '0);
        #3 rst = 1'b0;
        #1;
        check("async_reset_empty", {31'd0, empty}, 32'd1);
        check("async_reset_full", {31'd0, full}, 32'd0);
        model.delete();
        #1 rst = 1'b1;
        step(1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Randomized traffic
        for (int i = 0; i < 100; i++) begin
            r = int'($urandom_range(0, 99));
            if (model.size() == D) begin
                p = (r < 40);
                q = p || ($urandom_range(0, 1) == 1);
            end else begin
                p = (r < 60);
                q = (model.size() > 0) && ($urandom_range(0, 1) == 1);
            end
            step(p, q, W'($urandom));
        end
        while (model.size() > 0) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        #2;
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/flip_flop_fifo_with_counter.md
# flip_flop_fifo_with_counter

Synchronous single-clock FIFO built from a flip-flop storage array, with read/write pointers and an occupancy counter driving the `empty`/`full` flags. It is a small buffering primitive between a producer (push side) and a consumer (pop side) with show-ahead read data. It is paired with a verification companion, `fifo_monitor`, which checks it against a reference queue model.

## Interface
- `width`, default 8: data word width in bits.
- `depth`, default 5: number of entries. Any value ≥ 2 is legal, including non-powers-of-two.
- `fifo_monitor` only: `allow_push_when_full_with_pop`, default 1. When 1, simultaneous push and pop while full is legal.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `push`, input, 1: write request for the current cycle.
- `pop`, input, 1: read/consume request for the current cycle.
- `write_data`, input, `width`: data written when a push is accepted.
- `read_data`, output, `width`: head-of-FIFO word, show-ahead.
- `empty`, output, 1: high when occupancy is 0.
- `full`, output, 1: high when occupancy equals `depth`.

`fifo_monitor` has the same port list; all of its ports are inputs.

## Operation
- **State:**
  - storage array of `depth` × `width` flops;
  - `wr_ptr` and `rd_ptr`, each `$clog2(depth)` bits;
  - `cnt`, `$clog2(depth+1)` bits.
- **Pointer wrap:** each pointer increments and wraps from `depth-1` to 0 explicitly. Power-of-two overflow must not be relied on.
- **Accepted operations:**
  - Push accepted when `push & (~full | pop)`: `mem[wr_ptr] <= write_data`, `wr_ptr` advances.
  - Pop accepted when `pop & ~empty`: `rd_ptr` advances.
- **Counter update:**
  - +1 on accepted push only.
  - −1 on accepted pop only.
  - Unchanged when both are accepted, or when neither is.
- **Flags:** `empty = (cnt == 0)`, `full = (cnt == depth)`. Both are combinational from registers, with no input-to-output paths.
- **Read data:** `read_data = mem[rd_ptr]`, combinational from registers. When `empty`, the value is don't-care (stale).
- **Boundary cases:**
  - Push while full with no pop: ignored; no state change.
  - Pop while empty: ignored.
  - Push + pop while empty: push accepted, pop ignored, `cnt` becomes 1. There is no bypass path.
  - Push + pop while full: both accepted, `cnt` stays at `depth`. The write lands in the slot being freed (`wr_ptr == rd_ptr`). `read_data` shows the old head this cycle and the next entry after the edge.
- **Reset:** `rst` low asynchronously clears `wr_ptr`, `rd_ptr` and `cnt`, so `empty=1` and `full=0`. Storage contents are not reset. Asserting reset mid-operation discards all queued data.
- **`fifo_monitor`:**
  - Keeps a queue model, updated on the rising clock edge using the same acceptance rules.
  - On each accepted pop, compares `read_data` with the model head.
  - Every cycle, compares `empty` and `full` with the model occupancy.
  - Flags push-on-full (unless `pop` is high and `allow_push_when_full_with_pop=1`) and pop-on-empty as protocol errors.
  - On any mismatch or error, prints the expected and actual values and ends the simulation with a failure.
  - Clears its model while `rst` is low.

## Timing
- Write latency is 1 cycle. A word pushed at edge N is visible on `read_data`, with `empty` low, after edge N when the FIFO was empty.
- Pop is acknowledged in the same cycle: `read_data` is valid while `pop` is high, and the head advances at the edge.
- Flag changes appear immediately after the edge that changes `cnt`.
- Sustained push+pop gives 1 word per cycle throughput at any occupancy from 1 to `depth`.
- Outputs settle shortly after the clock edge. Stimulus sampling flags must look after the edge, not at it.

## Test plan
- **Fill and drain:** after reset, push 0x00, 0x11, 0x22, 0x33, 0x44 on consecutive cycles → `full=1` after the 5th edge. Then pop for 5 cycles → `read_data` is 0x00…0x44 in order, and `empty=1` at the end.
- **Back-to-back streaming:** push 2 words, then hold push and pop for 25 cycles with data repeating 0x00…0x44. Then release push and pop until `empty` → data comes out in push order, no loss or duplication, `full` never asserted.
- **Push+pop while full:** fill with 0x10…0x14, then push 0xAA with pop for 1 cycle → `read_data` was 0x10 that cycle, `cnt` stays 5, `full` stays 1. Draining then yields 0x11…0x14, 0xAA.
- **Illegal requests:**
  - Push 0x55 while full without pop → ignored; contents unchanged.
  - Pop while empty → `empty` stays 1; the next pushed word is the first one read.
- **Reset mid-operation:** with 3 entries queued, pulse `rst` low asynchronously between edges → `empty=1` and `full=0` immediately. A subsequent push of 0x77 reads back as 0x77.
- **Randomized:** 100 cycles with pop probability 50% when not empty, push probability 60% when not full, and push+pop probability 40% when full, with random data → monitor reports no mismatch.
